// File: rtl/tdm_pkg.sv
// tdm_pkg: shared FSM state encoding and slot-count constants for the 8-slot TDM demux
package tdm_pkg;
  localparam int SLOTS = 8;
  localparam int SLOT_W = 3;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/tdm_slot_cnt.sv
// tdm_slot_cnt: slot counter (clk, rst async clear, en increments mod 8, ld loads 1 with priority, cnt = next slot)
module tdm_slot_cnt
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ld,
  output logic [SLOT_W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (ld) cnt <= SLOT_W'(1);
    else if (en) cnt <= cnt + SLOT_W'(1);
endmodule

// File: rtl/tdm_demux8.sv
// tdm_demux8: serial 8-slot TDM to parallel frame (in: clk, rst, en, din, frame_sync; out: y, frame_valid, slot, sync_err, locked)
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter bit SYNC_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              din,
  input  logic              frame_sync,
  output logic [SLOTS-1:0]  y,
  output logic              frame_valid,
  output logic [SLOT_W-1:0] slot,
  output logic              sync_err,
  output logic              locked
);
  state_t            r_state, w_next;
  logic [SLOTS-1:0]  r_shadow, r_y;
  logic              r_fv, r_err;
  logic              w_ld, w_inc, w_store, w_load_y, w_err, w_restart;
  logic [SLOT_W-1:0] w_idx;
  tdm_slot_cnt u_cnt (
    .clk (clk),
    .rst (rst),
    .en  (w_inc),
    .ld  (w_ld),
    .cnt (slot)
  );
  always_comb begin
    w_err     = en && r_state == RUN && SYNC_CHECK && ((slot == '0) != frame_sync);
    w_restart = en && (r_state == IDLE || w_err);
    w_ld      = w_restart && frame_sync;
    w_inc     = en && !w_restart;
    w_store   = w_ld || w_inc;
    w_idx     = w_restart ? '0 : slot;
    w_load_y  = w_inc && slot == SLOT_W'(SLOTS - 1);
    w_next    = w_restart ? (frame_sync ? RUN : IDLE) : r_state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_y      <= '0;
      r_fv     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_store) r_shadow[w_idx] <= din;
      if (w_load_y) r_y <= {din, r_shadow[SLOTS-2:0]};
      r_fv  <= w_load_y;
      r_err <= w_err;
    end
  assign y           = r_y;
  assign frame_valid = r_fv;
  assign sync_err    = r_err;
  assign locked      = r_state == RUN;
endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8: randomized and directed check of tdm_demux8 (both SYNC_CHECK settings) against a queue-based frame model
module tb_tdm_demux8;
  logic clk = 1'b0;
  logic rst, en, din, frame_sync;
  logic [7:0] y0, y1;
  logic fv0, fv1, err0, err1, lk0, lk1;
  logic [2:0] s0, s1;
  int n_tests = 0;
  int n_fail = 0;
  bit fq[2][$];
  bit lk[2];
  bit efv[2], eerr[2];
  logic [7:0] ey[2];
  always #5 clk = ~clk;
  tdm_demux8 #(.SYNC_CHECK(1'b1)) u0 (
    .clk(clk), .rst(rst), .en(en), .din(din), .frame_sync(frame_sync),
    .y(y0), .frame_valid(fv0), .slot(s0), .sync_err(err0), .locked(lk0)
  );
  tdm_demux8 #(.SYNC_CHECK(1'b0)) u1 (
    .clk(clk), .rst(rst), .en(en), .din(din), .frame_sync(frame_sync),
    .y(y1), .frame_valid(fv1), .slot(s1), .sync_err(err1), .locked(lk1)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      fq[i].delete();
      lk[i] = 0;
      ey[i] = 8'h00;
      efv[i] = 0;
      eerr[i] = 0;
    end
  endtask
  task automatic model(int i, bit e, bit d, bit f);
    bit sc;
    sc = (i == 0);
    efv[i] = 0;
    eerr[i] = 0;
    if (!e) return;
    if (!lk[i]) begin
      if (f) begin
        fq[i].delete();
        fq[i].push_back(d);
        lk[i] = 1;
      end
    end else if (sc && fq[i].size() == 0 && !f) begin
      eerr[i] = 1;
      lk[i] = 0;
    end else if (sc && fq[i].size() != 0 && f) begin
      eerr[i] = 1;
      fq[i].delete();
      fq[i].push_back(d);
    end else begin
      fq[i].push_back(d);
      if (fq[i].size() == 8) begin
        for (int k = 0; k < 8; k++) ey[i][k] = fq[i][k];
        efv[i] = 1;
        fq[i].delete();
      end
    end
  endtask
  task automatic check_all();
    chk("y0", y0, ey[0]);
    chk("fv0", fv0, efv[0]);
    chk("err0", err0, eerr[0]);
    chk("slot0", s0, fq[0].size());
    chk("lock0", lk0, lk[0]);
    chk("y1", y1, ey[1]);
    chk("fv1", fv1, efv[1]);
    chk("err1", err1, eerr[1]);
    chk("slot1", s1, fq[1].size());
    chk("lock1", lk1, lk[1]);
    chk("excl0", fv0 & err0, 0);
  endtask
  task automatic cyc(bit e, bit d, bit f);
    en = e;
    din = d;
    frame_sync = f;
    @(posedge clk);
    model(0, e, d, f);
    model(1, e, d, f);
    #1;
    check_all();
  endtask
  task automatic send_frame(logic [7:0] v, bit gaps);
    for (int k = 0; k < 8; k++) begin
      cyc(1, v[k], k == 0);
      if (gaps && k < 7) cyc(0, 0, 0);
    end
  endtask
  task automatic async_reset();
    #2 rst = 1;
    mreset();
    #1 check_all();
    @(posedge clk);
    #1 rst = 0;
  endtask
  initial begin
    int pos;
    rst = 1;
    en = 0;
    din = 0;
    frame_sync = 0;
    mreset();
    #1 check_all();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    cyc(1, 1, 0);
    send_frame(8'h4D, 0);
    chk("f4D_y", y0, 8'h4D);
    chk("f4D_fv", fv0, 1);
    chk("f4D_lk", lk0, 1);
    send_frame(8'hA5, 0);
    chk("fA5_y", y0, 8'hA5);
    send_frame(8'h3C, 0);
    chk("f3C_y", y0, 8'h3C);
    chk("f3C_fv", fv0, 1);
    send_frame(8'hF0, 1);
    chk("fF0_y", y0, 8'hF0);
    chk("fF0_fv", fv0, 1);
    cyc(0, 1, 1);
    chk("hold_slot", s0, 0);
    for (int k = 0; k < 4; k++) cyc(1, 0, k == 0);
    cyc(1, 1, 1);
    chk("resync_err", err0, 1);
    chk("resync_fv", fv0, 0);
    chk("resync_slot", s0, 1);
    for (int k = 1; k < 8; k++) cyc(1, k == 7, 0);
    chk("f81_y", y0, 8'h81);
    chk("f81_fv", fv0, 1);
    async_reset();
    send_frame(8'h5A, 0);
    cyc(1, 1, 0);
    chk("nosync_err", err0, 1);
    chk("nosync_lk", lk0, 0);
    chk("nosync_y", y0, 8'h5A);
    chk("nc_err", err1, 0);
    chk("nc_lk", lk1, 1);
    async_reset();
    for (int k = 0; k < 5; k++) cyc(1, 1, k == 0);
    chk("pre_rst_slot", s0, 5);
    async_reset();
    chk("rst_y", y0, 0);
    send_frame(8'h77, 0);
    chk("f77_y", y0, 8'h77);
    chk("f77_fv", fv0, 1);
    pos = 0;
    for (int n = 0; n < 600; n++) begin
      bit e, d, f;
      e = ($urandom % 10) < 7;
      d = $urandom % 2;
      f = (pos == 0) ^ (($urandom % 16) == 0);
      cyc(e, d, f);
      if (e) pos = (pos + 1) % 8;
      if (($urandom % 200) == 0) begin
        async_reset();
        pos = 0;
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
